// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns one datapath request into a byte-enabled word access
// with a ready handshake, formats load data and reports misalignment/timeouts.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_off;

  logic        req_illegal;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;
  logic [31:0] ld_sel;
  logic [31:0] ld_data;
  logic        ld_sign;

  assign req_ready = (state == IDLE);

  // NOTE: every output of always_comb gets a default first so no latch is inferred.
  always_comb begin
    req_illegal = 1'b0;
    st_we       = 4'b0000;
    st_wdata    = 32'h0;
    unique case (req_size)
      2'b00: begin
        st_we    = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_illegal = req_addr[0];
        st_we       = req_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata    = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        req_illegal = (req_addr[1:0] != 2'b00);
        st_we       = 4'b1111;
        st_wdata    = req_wdata;
      end
      default: req_illegal = 1'b1;
    endcase
  end

  // Load data is shifted down to lane 0 and then extended per the latched size.
  always_comb begin
    ld_sel  = mem_rdata >> {lat_off, 3'b000};
    ld_sign = ~lat_unsigned;
    unique case (lat_size)
      2'b00:   ld_data = {{24{ld_sign & ld_sel[7]}}, ld_sel[7:0]};
      2'b01:   ld_data = {{16{ld_sign & ld_sel[15]}}, ld_sel[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= 8'd0;
      lat_we       <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_off      <= 2'b00;
      mem_en       <= 1'b0;
      mem_we       <= 4'b0000;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'h0;
      rsp_err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we       <= req_we;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_off      <= req_addr[1:0];
            wait_cnt     <= 8'd0;
            if (req_illegal) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else begin
              state     <= ACCESS;
              mem_en    <= 1'b1;
              mem_we    <= req_we ? st_we : 4'b0000;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= req_we ? st_wdata : 32'h0;
            end
          end
        end
        ACCESS: begin
          // A completing handshake wins over a timeout landing on the same edge.
          if (mem_ready) begin
            state     <= RESP;
            mem_en    <= 1'b0;
            mem_we    <= 4'b0000;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= lat_we ? 32'h0 : ld_data;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            state     <= RESP;
            mem_en    <= 1'b0;
            mem_we    <= 4'b0000;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus randomized
// transactions compared against an arithmetic model of lane/extension rules.
module tb_lsu_mem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  lsu_mem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        illegal;
    logic        err;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    int          n_access;
  } exp_t;

  // Expected outcome of one transaction, from byte-lane arithmetic.
  function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int waits);
    exp_t e;
    int off;
    int nbytes;
    longint v;
    e = '0;
    off = int'(addr % 4);
    e.addr = addr - 32'(off);
    e.illegal = (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && off != 0);
    if (e.illegal) begin
      e.err = 1'b1;
      e.lat = 1;
      e.n_access = 0;
      return e;
    end
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (waits >= TO) begin
      e.err = 1'b1;
      e.n_access = TO;
      e.lat = TO + 1;
    end else begin
      e.n_access = waits + 1;
      e.lat = waits + 2;
    end
    if (we) begin
      for (int lane = 0; lane < 4; lane++)
        if (lane >= off && lane < off + nbytes) e.we[lane] = 1'b1;
      if (nbytes == 1)      e.wdata = (wdata % 256) * 32'h0101_0101;
      else if (nbytes == 2) e.wdata = (wdata % 65536) * 32'h0001_0001;
      else                  e.wdata = wdata;
    end else if (!e.err) begin
      if (nbytes == 4) e.rdata = rdata;
      else begin
        v = longint'(rdata >> (8 * off)) % (longint'(1) << (8 * nbytes));
        if (!uns && v >= (longint'(1) << (8 * nbytes - 1))) v = v - (longint'(1) << (8 * nbytes));
        e.rdata = 32'(v);
      end
    end
    return e;
  endfunction

  task automatic run_txn(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int waits);
    exp_t e;
    bit seen;
    e = model(we, size, uns, addr, wdata, rdata, waits);
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s req_ready_idle: got %b want 1", name, req_ready);
    end
    mem_ready = 1'b0;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble request fields so the DUT must rely on what it latched.
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    seen = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      if (!e.illegal && waits < TO && cyc == waits + 1) mem_ready = 1'b1;
      else if (cyc > e.n_access) mem_ready = 1'($urandom);
      else mem_ready = 1'b0;
      mem_rdata = (mem_ready && cyc <= e.n_access) ? rdata : $urandom;
      @(negedge clk);
      tests++;
      if (mem_en !== (cyc <= e.n_access)) begin
        fails++;
        $display("FAIL %s mem_en cyc%0d: got %b want %b", name, cyc, mem_en, cyc <= e.n_access);
      end
      tests++;
      if (req_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s req_ready_busy cyc%0d: got %b want 0", name, cyc, req_ready);
      end
      if (cyc <= e.n_access) begin
        tests++;
        if (mem_addr !== e.addr || mem_we !== e.we) begin
          fails++;
          $display("FAIL %s mem_addr/we cyc%0d: got %h/%b want %h/%b", name, cyc,
                   mem_addr, mem_we, e.addr, e.we);
        end
        if (we) begin
          tests++;
          if (mem_wdata !== e.wdata) begin
            fails++;
            $display("FAIL %s mem_wdata cyc%0d: got %h want %h", name, cyc, mem_wdata, e.wdata);
          end
        end
      end
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        tests++;
        if (cyc != e.lat) begin
          fails++;
          $display("FAIL %s latency: got %0d want %0d", name, cyc, e.lat);
        end
        tests++;
        if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
          fails++;
          $display("FAIL %s rsp err/rdata: got %b/%h want %b/%h", name, rsp_err, rsp_rdata,
                   e.err, e.rdata);
        end
      end
      @(posedge clk); #1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s rsp_timeout: got no rsp_valid want one within 40 cycles", name);
    end
    mem_ready = 1'($urandom);
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 ||
        req_ready !== 1'b1 || mem_en !== 1'b0) begin
      fails++;
      $display("FAIL %s after_rsp: got v%b e%b d%h rdy%b en%b want v0 e0 d0 rdy1 en0", name,
               rsp_valid, rsp_err, rsp_rdata, req_ready, mem_en);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (req_ready !== 1'b1 || mem_en !== 1'b0 || mem_we !== 4'b0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got rdy%b en%b we%b a%h wd%h v%b d%h e%b want rdy1 rest 0",
               req_ready, mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_directed();
    run_txn("lb_0x103", 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);
    run_txn("lhu_0x102", 1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0, 32'h8001_0000, 3);
    run_txn("sb_0x201", 1'b1, 2'd0, 1'b0, 32'h0000_0201, 32'h1234_56AB, 32'h0, 1);
    run_txn("sh_0x202", 1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'hCAFE_BEEF, 32'h0, 0);
    run_txn("sw_0x300", 1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0, 2);
    run_txn("lh_signed", 1'b0, 2'd1, 1'b0, 32'h0000_0400, 32'h1234_9ABC, 32'h1234_9ABC, 0);
  endtask

  task automatic test_errors();
    run_txn("sw_misaligned", 1'b1, 2'd2, 1'b0, 32'h0000_0302, 32'h1111_2222, 32'h0, 0);
    run_txn("lh_misaligned", 1'b0, 2'd1, 1'b0, 32'h0000_0301, 32'h0, 32'h0, 0);
    run_txn("size_illegal", 1'b0, 2'd3, 1'b0, 32'h0000_0300, 32'h0, 32'h0, 0);
    run_txn("lw_timeout", 1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0, 32'h5555_AAAA, 100);
    run_txn("lw_last_wait", 1'b0, 2'd2, 1'b0, 32'h0000_0504, 32'h0, 32'h7777_1234, TO - 1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0; req_addr = 32'h0000_0602;
    req_wdata = 32'h0000_BEEF; req_valid = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_en !== 1'b1 || mem_we !== 4'b1100) begin
      fails++;
      $display("FAIL mid_reset_access: got en%b we%b want en1 we1100", mem_en, mem_we);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (mem_en !== 1'b0 || mem_we !== 4'b0 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_abandon: got en%b we%b v%b want 0 0 0", mem_en, mem_we, rsp_valid);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        fails++;
        $display("FAIL mid_reset_quiet%0d: got v%b rdy%b want v0 rdy1", i, rsp_valid, req_ready);
      end
    end
    run_txn("lw_after_reset", 1'b0, 2'd2, 1'b0, 32'h0000_0700, 32'h0, 32'h0BAD_F00D, 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'($urandom_range(0, 3)) & (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00);
      run_txn("random", 1'($urandom), 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2)),
              1'($urandom), a, $urandom, $urandom, $urandom_range(0, TO + 1));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
